// File: rtl/regfile_dbg_pkg.sv
// Shared types and defaults for the register-file dump reader.
// State encoding and word width used by the reader and its output FIFO.
package regfile_dbg_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_COUNT  = 32;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam int DEF_WORD_WIDTH = DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_dump_fifo.sv
// Small synchronous FIFO buffering {addr, data} words for the dump reader.
// Head entry is presented combinationally; flush empties it in one cycle.
module regfile_dump_fifo
    import regfile_dbg_pkg::*;
#(
    parameter int WIDTH = DEF_WORD_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full buffer is fine when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug reader: sweeps a register range through read port 1 and
// streams {addr, data} words out over a valid/ready interface.
module regfile_dump_reader
    import regfile_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_COUNT  = DEF_REG_COUNT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] A1,
    input  logic [DATA_WIDTH-1:0] RD1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] end_q;
    logic [ADDR_WIDTH-1:0] a1_q;

    logic [WORD_W-1:0]     head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  pop;
    logic                  push;
    logic                  flush;
    logic                  last_hit;
    logic [ADDR_WIDTH-1:0] cur_nxt;

    assign pop      = !fifo_empty && out_ready;
    assign flush    = abort && (state_q != ST_IDLE);
    assign push     = (state_q == ST_READ) && !abort && (!fifo_full || pop);
    assign last_hit = (cur_q == end_q);
    assign cur_nxt  = (cur_q == ADDR_WIDTH'(REG_COUNT - 1))
                      ? '0 : cur_q + ADDR_WIDTH'(1);

    // The final word is always pushed on the READ->DRAIN edge, so the
    // last accepted pop can only happen in DRAIN with one entry left.
    assign done = (state_q == ST_DRAIN) && !abort && pop
                  && (fifo_count == CW'(1));

    assign A1        = a1_q;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = !fifo_empty;
    assign out_addr  = head[WORD_W-1:DATA_WIDTH];
    assign out_data  = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            a1_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_READ;
                        cur_q   <= first_addr;
                        end_q   <= last_addr;
                        a1_q    <= first_addr;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (push) begin
                        if (last_hit) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            cur_q <= cur_nxt;
                            a1_q  <= cur_nxt;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort || done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    regfile_dump_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i ({cur_q, RD1}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
